// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared encodings and FIFO entry layout for imm_gen_pipe.
// Exports: IMM_I/S/B/U/J/Z format selects, XLEN_MAX/TAG_W_MAX bounds, entry_t.
// entry_t is sized for the widest build; instances use the low XLEN/TAG_W bits.
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 16;

    // One FIFO slot. Fields wider than the instance parameters are zero-filled.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  imm;
        logic [TAG_W_MAX-1:0] tag;
        logic                 illegal;
    } entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-side input channel and execute-side output channel.
// Ports: in_valid/in_ready/in_instr/in_sel/in_tag, out_valid/out_ready/out_imm/out_tag/out_illegal.
// master = producer/consumer side (testbench, decode/execute); slave = imm_gen_pipe.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational instr[31:7] + format select -> sign-extended immediate.
// Ports: instr_i (bits 31:7), sel_i, imm_o (XLEN), illegal_o.
// IMM_GEN_ZIMM_EN enables sel 101 (CSR zimm); otherwise 101 is illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr_i,
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Re-index so field slices read as instruction bit numbers.
    logic [31:7] ins;
    logic [31:0] raw;

    assign ins = instr_i;

    always_comb begin
        raw       = '0;
        illegal_o = 1'b0;
        case (sel_i)
            IMM_I: raw = {{20{ins[31]}}, ins[31:20]};
            IMM_S: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U: raw = {ins[31:12], 12'b0};
            IMM_J: raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_Z: raw = {27'b0, ins[19:15]};
`endif
            default: illegal_o = 1'b1;
        endcase
        // Every 32-bit form carries its sign in bit 31 (zimm has it clear),
        // so one signed widening covers XLEN=64 for all formats.
        imm_o = XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes immediates and queues {imm, tag, illegal} in a DEPTH-entry FIFO.
// Latency: push in cycle N visible at out_* in N+1; no combinational in->out path.
// Backpressure: in_ready = !full from registers only (no push while full even on pop).
// Ports: clk, rst_n (async active-low), flush (sync, highest priority), bus (imm_gen_pipe_if.slave).
// Build option IMM_GEN_ZIMM_EN: accept sel 101 as CSR zimm. TAG_W must not exceed TAG_W_MAX.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    entry_t        mem_q [DEPTH];

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    entry_t          wr_entry;
    entry_t          head;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.in_instr),
        .sel_i     (bus.in_sel),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        wr_entry                  = '0;
        wr_entry.imm[XLEN-1:0]    = dec_imm;
        wr_entry.tag[TAG_W-1:0]   = bus.in_tag;
        wr_entry.illegal          = dec_illegal;
    end

    assign bus.in_ready  = (count_q != FULL);
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign head            = mem_q[rd_ptr_q];
    assign bus.out_imm     = head.imm[XLEN-1:0];
    assign bus.out_tag     = head.tag[TAG_W-1:0];
    assign bus.out_illegal = head.illegal;

    // Upper bits of the max-width slot are always zero in narrower builds.
    logic unused_head;
    assign unused_head = ^head;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_sel;
    logic [4:0]  in_tag;
    logic        out_ready;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.in_sel    = in_sel;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.in_sel    = in_sel;
    assign if64.in_tag    = in_tag;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32)
    );
    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: field extraction by shifts on a sign-extended 64-bit word.
    function automatic logic [63:0] ref_imm(input logic [24:0] i25, input logic [2:0] sel,
                                            output bit ill);
        longint x;
        longint r;
        x   = longint'($signed({i25, 7'b0}));
        ill = 1'b0;
        r   = 0;
        case (sel)
            3'd0: r = x >>> 20;
            3'd1: r = ((x >>> 25) << 5) | ((x >> 7) & 31);
            3'd2: r = ((x >>> 31) << 12) | (((x >> 7) & 1) << 11)
                    | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
            3'd3: r = x & ~longint'(4095);
            3'd4: r = ((x >>> 31) << 20) | (((x >> 12) & 255) << 12)
                    | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
`ifdef IMM_GEN_ZIMM_EN
            3'd5: r = (x >> 15) & 31;
`endif
            default: begin r = 0; ill = 1'b1; end
        endcase
        return r;
    endfunction

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        bit          ill;
    } m_t;

    m_t q[$];

    // Model: an ordered queue of at most DEPTH entries.
    always @(posedge clk or negedge rst_n) begin
        bit do_pop;
        bit do_push;
        m_t e;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() != DEPTH);
            if (do_push) begin
                e.imm = ref_imm(in_instr, in_sel, e.ill);
                e.tag = in_tag;
            end
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            chk("rst out_valid", 64'(if32.out_valid), 64'd0);
            chk("rst in_ready", 64'(if32.in_ready), 64'd1);
            chk("rst out_imm", if64.out_imm, 64'd0);
            chk("rst out_tag", 64'(if32.out_tag), 64'd0);
            chk("rst out_illegal", 64'(if64.out_illegal), 64'd0);
        end else begin
            chk("out_valid32", 64'(if32.out_valid), 64'(q.size() != 0));
            chk("out_valid64", 64'(if64.out_valid), 64'(q.size() != 0));
            chk("in_ready32", 64'(if32.in_ready), 64'(q.size() != DEPTH));
            chk("in_ready64", 64'(if64.in_ready), 64'(q.size() != DEPTH));
            if (q.size() != 0) begin
                e = q[0].imm;
                chk("imm32", 64'(if32.out_imm), {32'b0, e[31:0]});
                chk("imm64", if64.out_imm, e);
                chk("tag32", 64'(if32.out_tag), 64'(q[0].tag));
                chk("tag64", 64'(if64.out_tag), 64'(q[0].tag));
                chk("illegal32", 64'(if32.out_illegal), 64'(q[0].ill));
                chk("illegal64", 64'(if64.out_illegal), 64'(q[0].ill));
            end
        end
    end

    task automatic setin(input logic [31:0] instr, input logic [2:0] sel, input logic [4:0] tag);
        in_valid = 1'b1;
        in_instr = instr[31:7];
        in_sel   = sel;
        in_tag   = tag;
    endtask

    // Called at a negedge with the FIFO empty; checks the entry one cycle later.
    task automatic send_one(input string nm, input logic [31:0] instr, input logic [2:0] sel,
                            input logic [63:0] e64, input logic ill);
        setin(instr, sel, 5'd9);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " valid"}, 64'(if32.out_valid), 64'd1);
        chk({nm, " imm32"}, 64'(if32.out_imm), {32'b0, e64[31:0]});
        chk({nm, " imm64"}, if64.out_imm, e64);
        chk({nm, " illegal"}, 64'(if32.out_illegal), 64'(ill));
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] held;
        logic [63:0] z_exp;
        logic        z_ill;
        bit          dummy;

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_sel = '0; in_tag = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the reference decode itself.
        chk("ref I", ref_imm(25'(32'hFFF00093 >> 7), 3'd0, dummy), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ref J", ref_imm(25'(32'h0080006F >> 7), 3'd4, dummy), 64'h8);

        send_one("I sign", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_one("B neg",  32'hFE000EE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_one("J pos",  32'h0080006F, 3'b100, 64'h0000_0000_0000_0008, 1'b0);
        send_one("U neg",  32'h80000037, 3'b011, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_one("U pos",  32'h12345037, 3'b011, 64'h0000_0000_1234_5000, 1'b0);
        send_one("S neg",  32'hFE112E23, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_one("sel7",   32'hFFFFFFFF, 3'b111, 64'h0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
        z_exp = 64'h16; z_ill = 1'b0;
`else
        z_exp = 64'h0;  z_ill = 1'b1;
`endif
        send_one("zimm", 32'h000B0000, 3'b101, z_exp, z_ill);

        // Backpressure: three pushes into a 2-deep FIFO with the consumer stalled.
        out_ready = 1'b0;
        setin(32'h7FF00093, 3'b000, 5'd1);
        @(negedge clk);
        setin(32'h00A12423, 3'b001, 5'd2);
        @(negedge clk);
        chk("bp in_ready full", 64'(if32.in_ready), 64'd0);
        chk("bp head tag1", 64'(if32.out_tag), 64'd1);
        chk("bp head imm", if64.out_imm, 64'h7FF);
        held = if64.out_imm;
        setin(32'h8000006F, 3'b100, 5'd3);
        repeat (2) begin
            @(negedge clk);
            chk("bp imm stable", if64.out_imm, held);
            chk("bp still full", 64'(if32.in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp tag2", 64'(if32.out_tag), 64'd2);
        chk("bp ready again", 64'(if32.in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp tag3", 64'(if64.out_tag), 64'd3);
        @(negedge clk);
        chk("bp drained", 64'(if32.out_valid), 64'd0);

        // Flush with a simultaneous push.
        out_ready = 1'b0;
        setin(32'h00100093, 3'b000, 5'd4);
        @(negedge clk);
        setin(32'h00200093, 3'b000, 5'd5);
        @(negedge clk);
        flush = 1'b1;
        setin(32'h00300093, 3'b000, 5'd6);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", 64'(if32.out_valid), 64'd0);
        chk("flush in_ready", 64'(if64.in_ready), 64'd1);

        // Reset pulse in the middle of a cycle.
        setin(32'h00400093, 3'b000, 5'd7);
        @(negedge clk);
        setin(32'h00500093, 3'b000, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(if32.out_valid), 64'd0);
        chk("arst out_valid64", 64'(if64.out_valid), 64'd0);
        chk("arst in_ready", 64'(if32.in_ready), 64'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_one("post rst", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = $urandom_range(1);
            in_instr  = 25'($urandom);
            in_sel    = 3'($urandom_range(7));
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(31) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, buffered immediate generator for the decode stage.
- Accepts instruction bits [31:7] plus a format select over a valid/ready handshake, builds the sign-extended immediate at XLEN width, and queues results in a DEPTH-entry FIFO toward execute.
- Supports XLEN 32/64, a tag passthrough, an illegal-format flag, and pipeline flush.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64
DEPTH, 2, output FIFO entries; power of two, >=2
TAG_W, 5, width of the sideband tag carried with each entry (e.g. rd or ROB index)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; empties the FIFO
in_valid  input  1  input entry valid
in_ready  output  1  FIFO can accept this cycle
in_instr  input  25  instruction bits [31:7]
in_sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (optional), others illegal
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_imm  output  XLEN  immediate of head entry
out_tag  output  TAG_W  tag of head entry
out_illegal  output  1  head entry had an unsupported in_sel

Behaviour:
- Reset: asynchronous, active-low (rst_n low clears state immediately, independent of clk).
  - Clears count, rd_ptr and wr_ptr.
  - Outputs during reset: out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- Decode is combinational on the input side. Bit positions below are instruction bits; s(x) means sign-extend x from instr[31] to XLEN.
  - I: s(instr[31:20])
  - S: s({instr[31:25], instr[11:7]})
  - B: s({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: s({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 = instr[31]
  - J: s({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - Illegal sel: imm=0, illegal=1. Legal sel: illegal=0.
- Push: in_valid && in_ready. Decoded imm, tag and illegal are written at wr_ptr.
- Pop: out_valid && out_ready. Advances rd_ptr.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no combinational in→out path.
- in_ready = (count != DEPTH), driven from registers only. It does not depend on out_ready, so there is no push while full, even if a pop happens in the same cycle.
- out_valid = (count != 0). out_imm, out_tag and out_illegal always show mem[rd_ptr]. They hold stable while out_valid && !out_ready.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- flush has priority over push and pop. Next cycle: count=0, pointers=0, out_valid=0. Any push in the flush cycle is discarded.
- Reset asserted mid-operation discards all entries. The first push after rst_n rises is accepted normally.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN
- Defined: sel 101 decodes the CSR zimm format, imm = zero-extend(instr[19:15]), illegal=0.
- Undefined: sel 101 is illegal (imm=0, illegal=1).

Decomposition:
- Package imm_pkg holds:
  - localparams IMM_I/IMM_S/IMM_B/IMM_U/IMM_J/IMM_Z (3-bit encodings)
  - typedef of the FIFO entry struct {imm, tag, illegal}
- Sub-module imm_decode: purely combinational sel→{imm, illegal}, parametrised on XLEN; instantiated once ahead of the FIFO write port.
- The FIFO storage and control live in imm_gen_pipe.

Test Plan:
- I-type sign: XLEN=32, instr=0xFFF00093, sel=000, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- B-type: instr=0xFE000EE3, sel=010 → out_imm=0xFFFFFFFC. J-type with instr=0x0080006F, sel=100 → out_imm=0x00000008.
- U-type width: XLEN=64, instr=0x80000037, sel=011 → out_imm=0xFFFFFFFF80000000. With instr=0x12345037 → 0x0000000012345000.
- Backpressure: DEPTH=2, out_ready=0, three back-to-back pushes with tags 1, 2, 3.
  - Expect in_ready=0 after the 2nd accept; tag 3 is held by the source.
  - Raise out_ready → tags pop in order 1, 2, 3; out_imm is stable while stalled.
- Illegal/optional: sel=111 → out_imm=0, out_illegal=1. sel=101 with instr[19:15]=5'b10110 → 0x16 when IMM_GEN_ZIMM_EN is defined, else illegal=1.
- Flush/reset: fill 2 entries, assert flush together with in_valid → next cycle out_valid=0, in_ready=1. Refill, pulse rst_n low mid-cycle → out_valid=0 immediately.
